// File: rtl/lzma2_output_serializer_pkg.sv
// Shared types, constants and byte-lane helpers for the LZMA2 output serializer.
package lzma2_output_serializer_pkg;

    localparam logic [7:0] LZMA2_END_MARKER   = 8'h00;
    localparam int         SER_BEATS_PER_WORD = 8;
    localparam logic [5:0] SER_WORD_BYTES     = 6'd32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        MARKER  = 2'd2,
        TRAILER = 2'd3
    } ser_state_t;

    // A word is legal when it carries 1..32 bytes, and exactly 32 unless it closes the stream.
    function automatic logic bytes_legal(input logic [5:0] n, input logic last);
        logic ok;
        if (n == 6'd0 || n > SER_WORD_BYTES) begin
            ok = 1'b0;
        end else if (!last && n != SER_WORD_BYTES) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [3:0] keep_for(input logic [5:0] rem);
        logic [3:0] k;
        if (rem >= 6'd4) begin
            k = 4'b1111;
        end else begin
            case (rem[1:0])
                2'd0:    k = 4'b0000;
                2'd1:    k = 4'b0001;
                2'd2:    k = 4'b0011;
                2'd3:    k = 4'b0111;
                default: k = 4'b0000;
            endcase
        end
        return k;
    endfunction

    function automatic logic [2:0] beat_bytes(input logic [5:0] rem);
        logic [2:0] b;
        if (rem >= 6'd4) begin
            b = 3'd4;
        end else begin
            b = rem[2:0];
        end
        return b;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] w, input logic [3:0] keep);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            r[8*j +: 8] = keep[j] ? w[8*j +: 8] : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [31:0] lane_pick(input logic [255:0] w, input logic [2:0] idx);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int i = 0; i < SER_BEATS_PER_WORD; i++) begin
            if (idx == 3'(i)) begin
                r = w[32*i +: 32];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lzma2_output_serializer_if.sv
// Word-in / beat-out stream bundle between the compression engine, serializer and host side.
interface lzma2_output_serializer_if;

    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [5:0]   in_bytes;
    logic [31:0]  out_data;
    logic [3:0]   out_keep;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output in_data, in_valid, in_last, in_bytes, out_ready,
        input  in_ready, out_data, out_keep, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, out_ready,
        output in_ready, out_data, out_keep, out_valid, out_last
    );

endinterface

// File: rtl/lzma2_output_serializer.sv
// Serializes 256-bit compressed words into 32-bit little-endian beats, then appends
// the end-of-stream marker and an optional payload byte-count trailer.
module lzma2_output_serializer
    import lzma2_output_serializer_pkg::*;
#(
    parameter bit         EMIT_TRAILER = 1'b1,
    parameter logic [7:0] END_MARKER   = LZMA2_END_MARKER
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lzma2_output_serializer_if.slave bus,
    output logic                     busy,
    output logic [31:0]              byte_count,
    output logic                     proto_err
);

    ser_state_t   state_r, state_s;
    logic [255:0] buf_r, buf_s;
    logic [5:0]   rem_r, rem_s;
    logic [2:0]   idx_r, idx_s;
    logic         last_r, last_s;
    logic         out_valid_r, out_valid_s;
    logic [31:0]  out_data_r, out_data_s;
    logic [3:0]   out_keep_r, out_keep_s;
    logic         out_last_r, out_last_s;
    logic         busy_r, busy_s;
    logic [31:0]  count_r, count_s;
    logic         proto_err_r, proto_err_s;
    logic         new_stream_r, new_stream_s;
    logic         ready_en_r;

    logic         in_ready_s, accept_s, hs_s, legal_s;
    logic [5:0]   eff_s, rem_next_s;
    logic [2:0]   idx_next_s;
    logic [3:0]   keep_next_s, keep_load_s;

    // Holds in_ready low while reset is asserted and until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Word acceptance: idle, or chaining onto the final beat of a non-last word.
    always_comb begin
        in_ready_s = 1'b0;
        if (!ready_en_r) begin
            in_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == SHIFT && rem_r <= 6'd4 && !last_r) begin
            in_ready_s = bus.out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // Next-state and next-beat computation; outputs are registered from these values.
    always_comb begin
        state_s      = state_r;
        buf_s        = buf_r;
        rem_s        = rem_r;
        idx_s        = idx_r;
        last_s       = last_r;
        out_valid_s  = out_valid_r;
        out_data_s   = out_data_r;
        out_keep_s   = out_keep_r;
        out_last_s   = out_last_r;
        busy_s       = busy_r;
        count_s      = count_r;
        proto_err_s  = proto_err_r;
        new_stream_s = new_stream_r;

        hs_s        = out_valid_r && bus.out_ready;
        accept_s    = in_ready_s && bus.in_valid;
        legal_s     = bytes_legal(bus.in_bytes, bus.in_last);
        eff_s       = legal_s ? bus.in_bytes : SER_WORD_BYTES;
        keep_load_s = keep_for(eff_s);
        rem_next_s  = rem_r - 6'd4;
        idx_next_s  = idx_r + 3'd1;
        keep_next_s = keep_for(rem_next_s);

        case (state_r)
            IDLE: begin
                out_valid_s = 1'b0;
            end
            SHIFT: begin
                if (hs_s) begin
                    count_s = count_r + {29'd0, beat_bytes(rem_r)};
                    if (rem_r > 6'd4) begin
                        rem_s      = rem_next_s;
                        idx_s      = idx_next_s;
                        out_keep_s = keep_next_s;
                        out_data_s = lane_mask(lane_pick(buf_r, idx_next_s), keep_next_s);
                    end else if (last_r) begin
                        state_s    = MARKER;
                        out_data_s = {24'h00_0000, END_MARKER};
                        out_keep_s = 4'b0001;
                        out_last_s = !EMIT_TRAILER;
                    end else begin
                        // Mid-stream gap; a same-cycle accept below overrides this.
                        state_s     = IDLE;
                        out_valid_s = 1'b0;
                        out_data_s  = 32'h0000_0000;
                        out_keep_s  = 4'b0000;
                        out_last_s  = 1'b0;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            MARKER: begin
                if (hs_s && EMIT_TRAILER) begin
                    state_s    = TRAILER;
                    out_data_s = count_r;
                    out_keep_s = 4'b1111;
                    out_last_s = 1'b1;
                end else if (hs_s) begin
                    state_s      = IDLE;
                    out_valid_s  = 1'b0;
                    out_data_s   = 32'h0000_0000;
                    out_keep_s   = 4'b0000;
                    out_last_s   = 1'b0;
                    busy_s       = 1'b0;
                    new_stream_s = 1'b1;
                end else begin
                    state_s = MARKER;
                end
            end
            TRAILER: begin
                if (hs_s) begin
                    state_s      = IDLE;
                    out_valid_s  = 1'b0;
                    out_data_s   = 32'h0000_0000;
                    out_keep_s   = 4'b0000;
                    out_last_s   = 1'b0;
                    busy_s       = 1'b0;
                    new_stream_s = 1'b1;
                end else begin
                    state_s = TRAILER;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
                out_data_s  = 32'h0000_0000;
                out_keep_s  = 4'b0000;
                out_last_s  = 1'b0;
            end
        endcase

        if (accept_s) begin
            state_s      = SHIFT;
            buf_s        = bus.in_data;
            rem_s        = eff_s;
            idx_s        = 3'd0;
            last_s       = bus.in_last;
            out_valid_s  = 1'b1;
            out_keep_s   = keep_load_s;
            out_data_s   = lane_mask(bus.in_data[31:0], keep_load_s);
            out_last_s   = 1'b0;
            busy_s       = 1'b1;
            new_stream_s = 1'b0;
            // Only reachable from IDLE, so no payload count update competes with the clear.
            if (new_stream_r) begin
                count_s = 32'h0000_0000;
            end else begin
                count_s = count_s;
            end
            if (!legal_s) begin
                proto_err_s = 1'b1;
            end else begin
                proto_err_s = proto_err_s;
            end
        end else begin
            new_stream_s = new_stream_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            buf_r        <= 256'd0;
            rem_r        <= 6'd0;
            idx_r        <= 3'd0;
            last_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 32'h0000_0000;
            out_keep_r   <= 4'b0000;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            count_r      <= 32'h0000_0000;
            proto_err_r  <= 1'b0;
            new_stream_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            buf_r        <= buf_s;
            rem_r        <= rem_s;
            idx_r        <= idx_s;
            last_r       <= last_s;
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            out_keep_r   <= out_keep_s;
            out_last_r   <= out_last_s;
            busy_r       <= busy_s;
            count_r      <= count_s;
            proto_err_r  <= proto_err_s;
            new_stream_r <= new_stream_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_keep  = out_keep_r;
    assign bus.out_last  = out_last_r;
    assign busy          = busy_r;
    assign byte_count    = count_r;
    assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_lzma2_output_serializer.sv
// Directed bench for lzma2_output_serializer with a beat scoreboard fed at stimulus time.
module tb_lzma2_output_serializer;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [31:0] byte_count;
    logic        proto_err;

    lzma2_output_serializer_if bus();

    lzma2_output_serializer #(
        .EMIT_TRAILER (1'b1),
        .END_MARKER   (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .byte_count (byte_count),
        .proto_err  (proto_err)
    );

    int          n_err = 0;
    int          n_checks = 0;
    logic [36:0] sb_q[$];
    logic [31:0] model_cnt = 32'd0;
    bit          new_stream = 1'b1;
    int          hs_count = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          rand_mode = 1'b0;
    bit          ready_hold = 1'b0;
    bit          stall_q = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_k;
    logic        prev_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sink side: out_ready is either held or randomly toggled.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_hold;
        end
    end

    // Output monitor: scoreboard pop on each handshake and stall-stability checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_data", bus.out_data, prev_d);
                check("stall_keep", {28'd0, bus.out_keep}, {28'd0, prev_k});
                check("stall_last", {31'd0, bus.out_last}, {31'd0, prev_l});
            end
            if (bus.out_valid && bus.out_ready) begin
                logic [36:0] e;
                hs_count++;
                n_checks++;
                assert (sb_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_underflow: observed beat %h, expected no beat", bus.out_data);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("beat_data", bus.out_data, e[31:0]);
                    check("beat_keep", {28'd0, bus.out_keep}, {28'd0, e[35:32]});
                    check("beat_last", {31'd0, bus.out_last}, {31'd0, e[36]});
                end
            end
            stall_q = bus.out_valid && !bus.out_ready;
            prev_d  = bus.out_data;
            prev_k  = bus.out_keep;
            prev_l  = bus.out_last;
        end
    end

    // Reference beats for one word (plus marker and trailer if it closes the stream).
    task automatic expect_word(input logic [255:0] d, input int eff, input logic lst);
        int          rem;
        int          j;
        logic [31:0] w;
        logic [3:0]  k;
        rem = eff;
        j = 0;
        if (new_stream) begin
            model_cnt  = 32'd0;
            new_stream = 1'b0;
        end
        while (rem > 0) begin
            w = d[32*j +: 32];
            k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            for (int b = 0; b < 4; b++) begin
                if (!k[b]) w[8*b +: 8] = 8'h00;
            end
            sb_q.push_back({1'b0, k, w});
            rem = rem - 4;
            j++;
        end
        model_cnt = model_cnt + 32'(eff);
        if (lst) begin
            sb_q.push_back({1'b0, 4'h1, 32'h0000_0000});
            sb_q.push_back({1'b1, 4'hF, model_cnt});
            new_stream = 1'b1;
        end
    endtask

    task automatic send_word(input logic [255:0] d, input logic [5:0] nb, input logic lst);
        int t;
        bus.in_data  = d;
        bus.in_bytes = nb;
        bus.in_last  = lst;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("accept_in_time", {31'd0, bus.in_ready}, 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] d;
        logic [255:0] d2;
        int           a1;
        int           a2;
        int           base;
        int           t;

        bus.in_data  = 256'd0;
        bus.in_bytes = 6'd0;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_byte_count", byte_count, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_hold = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Full last word with bytes 0x00..0x1F.
        for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
        expect_word(d, 32, 1'b1);
        send_word(d, 6'd32, 1'b1);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        drain();
        check("busy_after_stream", {31'd0, busy}, 32'd0);
        check("count_full", byte_count, 32'd32);

        // Partial last word, 5 bytes, with junk above byte 4 that must be masked.
        d = {27{8'hEE}} << 40;
        for (int i = 0; i < 5; i++) d[8*i +: 8] = 8'(8'hA0 + i);
        sb_q.push_back({1'b0, 4'hF, 32'hA3A2_A1A0});
        sb_q.push_back({1'b0, 4'h1, 32'h0000_00A4});
        sb_q.push_back({1'b0, 4'h1, 32'h0000_0000});
        sb_q.push_back({1'b1, 4'hF, 32'h0000_0005});
        send_word(d, 6'd5, 1'b1);
        drain();
        check("count_partial", byte_count, 32'd5);

        // Three back-to-back full words: each next word accepted on the previous 8th beat.
        d = rand_word();
        d2 = rand_word();
        expect_word(d, 32, 1'b0);
        expect_word(d2, 32, 1'b0);
        expect_word(~d, 32, 1'b1);
        send_word(d, 6'd32, 1'b0);
        a1 = acc_cyc;
        send_word(d2, 6'd32, 1'b0);
        a2 = acc_cyc;
        check("b2b_gap_1", 32'(a2 - a1), 32'd8);
        send_word(~d, 6'd32, 1'b1);
        check("b2b_gap_2", 32'(acc_cyc - a2), 32'd8);
        drain();
        check("count_b2b", byte_count, 32'd96);

        // Two-word stream under random back-pressure.
        rand_mode = 1'b1;
        d = rand_word();
        d2 = rand_word();
        expect_word(d, 32, 1'b0);
        expect_word(d2, 19, 1'b1);
        send_word(d, 6'd32, 1'b0);
        send_word(d2, 6'd19, 1'b1);
        drain();
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        check("count_random", byte_count, 32'd51);

        // Reset in the middle of a word.
        d = rand_word();
        expect_word(d, 32, 1'b0);
        base = hs_count;
        send_word(d, 6'd32, 1'b0);
        t = 0;
        while (hs_count < base + 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_beats_seen", 32'(hs_count - base), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_out_data", bus.out_data, 32'd0);
        check("mid_rst_out_keep", {28'd0, bus.out_keep}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_byte_count", byte_count, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sb_q.delete();
        new_stream = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d = rand_word();
        expect_word(d, 12, 1'b1);
        send_word(d, 6'd12, 1'b1);
        drain();
        check("count_after_reset", byte_count, 32'd12);

        // Illegal 7-byte non-last word: treated as 32 bytes, error is sticky.
        d = rand_word();
        expect_word(d, 32, 1'b0);
        send_word(d, 6'd7, 1'b0);
        check("proto_err_set", {31'd0, proto_err}, 32'd1);
        d = rand_word();
        expect_word(d, 4, 1'b1);
        send_word(d, 6'd4, 1'b1);
        drain();
        check("count_proto", byte_count, 32'd36);
        d = rand_word();
        expect_word(d, 32, 1'b1);
        send_word(d, 6'd32, 1'b1);
        drain();
        check("proto_err_sticky", {31'd0, proto_err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/lzma2_output_serializer.md
# lzma2_output_serializer

Downstream stage of the LZMA2 compression top level. Accepts 256-bit compressed words from the engine's output port and serializes them into a 32-bit little-endian byte stream with per-byte keep strobes. After the last payload word it appends the LZMA2 end-of-stream marker beat and, optionally, a 32-bit total-payload-byte trailer. The result feeds the host/DMA interface.

## Interface
- `EMIT_TRAILER`, default 1: append the byte-count trailer beat after the end marker.
- `END_MARKER`, default 8'h00: value of the LZMA2 end-of-stream control byte.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 256: compressed word; byte i = `in_data[8i+7:8i]`.
- `in_valid` in 1: word valid.
- `in_ready` out 1: word accepted when `in_valid && in_ready`.
- `in_last` in 1: final payload word of the stream.
- `in_bytes` in 6: valid bytes in the word, 1..32. Non-last words must carry 32.
- `out_data` out 32: output beat; lane j = `out_data[8j+7:8j]`.
- `out_keep` out 4: byte-valid strobes, contiguous from lane 0.
- `out_valid` out 1: beat valid.
- `out_ready` in 1: beat consumed when `out_valid && out_ready`.
- `out_last` out 1: final beat of the stream.
- `busy` out 1: high from word acceptance until the final beat is consumed.
- `byte_count` out 32: payload bytes emitted in the current/last stream; wraps mod 2^32.
- `proto_err` out 1: sticky; set on an illegal `in_bytes`.

## Operation
- States:
  - IDLE: buffer empty, `in_ready`=1.
  - SHIFT: emitting buffered word.
  - MARKER: emitting end-marker beat.
  - TRAILER: emitting count beat.
- IDLE transitions:
  - Accepted word → SHIFT. Capture data, `rem` = effective bytes, `beat_idx` = 0, and `last_q` = `in_last`.
  - If this is the first word since the previous stream end, `byte_count` is cleared before accumulating.
- SHIFT:
  - `out_data` = `in_data[32*beat_idx +: 32]`.
  - `out_keep` = 4'b1111 if `rem` ≥ 4, else the low `rem` bits set. Lanes ≥ `rem` are driven 0.
  - On handshake: `rem` -= min(`rem`,4), `beat_idx`++, `byte_count` += the number of keep bits.
- End of word (`rem` ≤ 4 beat handshake):
  - `last_q`=0 → the next word may load in the same cycle (see Timing); otherwise → IDLE.
  - `last_q`=1 → MARKER.
- MARKER: `out_data` = {24'h0, `END_MARKER`}, `out_keep` = 4'b0001, `out_last` = !`EMIT_TRAILER`. On handshake → TRAILER if `EMIT_TRAILER`, else IDLE.
- TRAILER: `out_data` = `byte_count` (marker byte not counted), `out_keep` = 4'b1111, `out_last` = 1. On handshake → IDLE.
- Illegal `in_bytes` (0, >32, or ≠32 on a non-last word): set `proto_err` and treat the word as 32 bytes. `proto_err` is cleared only by reset.
- `out_last` is asserted only on the final beat. Payload beats never assert it.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in IDLE after reset. `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `busy`=0, `byte_count`=0, `proto_err`=0, state IDLE.
- Latency: a word accepted at cycle t presents its first beat at t+1. A full word takes 8 beats, a partial word ceil(n/4) beats.
- `in_ready` = IDLE, or (SHIFT && `rem` ≤ 4 && `!last_q` && `out_ready`). This is a combinational path from `out_ready` and is permitted.
- Back-to-back words with `out_ready` held high sustain 1 beat/cycle with no bubble.
- `out_data`, `out_keep`, `out_last` are registered and held stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake.
- `busy` rises the cycle after acceptance and falls the cycle after the final beat handshake.
- Simultaneous final-beat handshake and new-word accept: the new word's beat 0 appears the next cycle. `byte_count` reflects both updates correctly.
- `byte_count` wraps 0xFFFFFFFF → 0 silently. The trailer carries the wrapped value.
- `rst_n` asserted mid-stream: all state is discarded immediately and no further beats are produced. The stream is not completed.

## Structure
- `lzma2_pkg` additions:
  - `LZMA2_END_MARKER` constant.
  - `ser_state_t` enum {IDLE, SHIFT, MARKER, TRAILER}.
  - `SER_BEATS_PER_WORD` = 8.
- Single module, no sub-modules. The 256→32 lane mux is inline.

## Test plan
- One 32-byte last word with bytes 0x00..0x1F and `out_ready`=1:
  - 8 beats, the first 0x03020100 and the eighth 0x1F1E1D1C, all keep 1111.
  - Marker beat 0x00000000 with keep 0001.
  - Trailer 0x00000020 with `out_last`=1.
- Last word with `in_bytes`=5, data bytes 0xA0..0xA4:
  - Beats 0xA3A2A1A0 with keep 1111, then 0x000000A4 with keep 0001.
  - Marker beat, then trailer 0x00000005.
- Three back-to-back full words with `out_ready`=1:
  - 24 contiguous payload beats, `in_ready` high on each word's 8th beat.
  - Trailer 0x00000060.
- Random `out_ready` toggling (50%) on a 2-word stream:
  - Output matches the reference byte sequence.
  - No beat changes while stalled.
- Non-last word with `in_bytes`=7:
  - `proto_err` goes to 1.
  - 8 beats are emitted and `proto_err` stays high through the next stream.
- Reset asserted after beat 3 of a word:
  - All outputs go to their reset values and `byte_count`=0.
  - The next stream serializes correctly from beat 0.
